or1200_ss_retchk: RTL and testbench

Return-address checker sitting directly downstream of the OR1200 shadow stack. It receives each popped shadow entry and pairs it in order with the return target that EX actually resolves for the `l.jr r9` causing the pop. It compares the two and raises a held exception request to the exception unit on mismatch, underflow or orphaned return. It also keeps saturating match and violation counters for debug SPR readout.

---
 rtl/or1200_ss_retchk_pkg.sv | 22 ++
 rtl/or1200_ss_retchk_fifo.sv | 58 +++++
 rtl/or1200_ss_retchk.sv | 133 +++++++++++++
 tb/tb_or1200_ss_retchk.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_ss_retchk_pkg.sv
// Shared types and constants for the shadow-stack return-address checker.
package or1200_ss_retchk_pkg;

  localparam int OR1200_SSCHK_FIFO_DEPTH = 4;
  localparam int OR1200_SSCHK_CNT_W      = 16;

  localparam logic [1:0] OR1200_SSCHK_NONE      = 2'b00;
  localparam logic [1:0] OR1200_SSCHK_MISMATCH  = 2'b01;
  localparam logic [1:0] OR1200_SSCHK_UNDERFLOW = 2'b10;
  localparam logic [1:0] OR1200_SSCHK_ORPHAN    = 2'b11;

  typedef struct packed {
    logic        udf;
    logic [31:0] ra;
  } ss_entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REPORT = 1'b1
  } chk_state_t;

endpackage

// File: rtl/or1200_ss_retchk_fifo.sv
// Synchronous FIFO holding popped shadow entries until their return resolves.
module or1200_ss_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/or1200_ss_retchk.sv
// Pairs popped shadow-stack entries with resolved return targets and reports violations.
module or1200_ss_retchk
  import or1200_ss_retchk_pkg::*;
#(
  parameter int FIFO_DEPTH = OR1200_SSCHK_FIFO_DEPTH,
  parameter int CNT_W      = OR1200_SSCHK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_freeze,
  input  logic             chk_en,
  input  logic             pop_valid,
  input  logic [31:0]      pop_ra,
  input  logic             pop_empty,
  input  logic             ret_valid,
  input  logic [31:0]      ret_target,
  input  logic [31:0]      ret_pc,
  output logic             viol_req,
  input  logic             viol_ack,
  output logic [1:0]       viol_code,
  output logic [31:0]      viol_pc,
  output logic [31:0]      viol_exp,
  output logic [31:0]      viol_act,
  output logic             viol_lost,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             busy
);

  chk_state_t state_q, state_d;

  logic      acc_pop, acc_ret;
  logic      q_full, q_empty, q_push, q_pop;
  ss_entry_t q_head, pop_entry, cmp_entry;
  logic      has_entry;

  logic        viol, match;
  logic [1:0]  v_code;
  logic [31:0] v_pc, v_exp, v_act;

  assign acc_pop   = pop_valid && !ex_freeze && chk_en;
  assign acc_ret   = ret_valid && !ex_freeze && chk_en;
  assign pop_entry = '{udf: pop_empty, ra: pop_ra};

  // Empty queue with a same-cycle pop: the ret consumes the pop directly.
  assign has_entry = !q_empty || acc_pop;
  assign cmp_entry = q_empty ? pop_entry : q_head;
  assign q_pop     = acc_ret && !q_empty;
  assign q_push    = acc_pop && !(acc_ret && q_empty) && (!q_full || q_pop);

  or1200_ss_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (33)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (!chk_en),
    .din   (pop_entry),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    viol   = 1'b0;
    match  = 1'b0;
    v_code = OR1200_SSCHK_NONE;
    v_pc   = '0;
    v_exp  = '0;
    v_act  = '0;
    if (acc_ret) begin
      v_pc  = ret_pc;
      v_act = ret_target;
      if (!has_entry) begin
        viol   = 1'b1;
        v_code = OR1200_SSCHK_ORPHAN;
      end else if (cmp_entry.udf) begin
        viol   = 1'b1;
        v_code = OR1200_SSCHK_UNDERFLOW;
      end else if (cmp_entry.ra != ret_target) begin
        viol   = 1'b1;
        v_code = OR1200_SSCHK_MISMATCH;
        v_exp  = cmp_entry.ra;
      end else begin
        match = 1'b1;
      end
    end else if (acc_pop && q_full) begin
      // No dequeue this cycle, so a full queue has to drop the pop.
      viol   = 1'b1;
      v_code = OR1200_SSCHK_ORPHAN;
      v_exp  = pop_ra;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (viol) state_d = ST_REPORT;
      ST_REPORT: if (viol_ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      viol_code <= '0;
      viol_pc   <= '0;
      viol_exp  <= '0;
      viol_act  <= '0;
      viol_lost <= 1'b0;
      match_cnt <= '0;
      viol_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (viol && state_q == ST_IDLE) begin
        viol_code <= v_code;
        viol_pc   <= v_pc;
        viol_exp  <= v_exp;
        viol_act  <= v_act;
      end
      if (viol && state_q == ST_REPORT) viol_lost <= 1'b1;
      if (match && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
      if (viol && viol_cnt != '1)   viol_cnt  <= viol_cnt + 1'b1;
    end
  end

  assign viol_req = (state_q == ST_REPORT);
  assign busy     = !q_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_or1200_ss_retchk.sv
// Self-checking bench: directed vector table, corner sequences and random traffic vs a queue model.
module tb_or1200_ss_retchk;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_freeze = 1'b0, chk_en = 1'b1;
  logic        pop_valid = 1'b0, pop_empty = 1'b0, ret_valid = 1'b0, viol_ack = 1'b0;
  logic [31:0] pop_ra = '0, ret_target = '0, ret_pc = '0;
  logic        viol_req, viol_lost, busy;
  logic [1:0]  viol_code;
  logic [31:0] viol_pc, viol_exp, viol_act;
  logic [15:0] match_cnt, viol_cnt;

  int checks = 0;
  int errors = 0;

  or1200_ss_retchk dut (
    .clk(clk), .rst(rst), .ex_freeze(ex_freeze), .chk_en(chk_en),
    .pop_valid(pop_valid), .pop_ra(pop_ra), .pop_empty(pop_empty),
    .ret_valid(ret_valid), .ret_target(ret_target), .ret_pc(ret_pc),
    .viol_req(viol_req), .viol_ack(viol_ack), .viol_code(viol_code),
    .viol_pc(viol_pc), .viol_exp(viol_exp), .viol_act(viol_act),
    .viol_lost(viol_lost), .match_cnt(match_cnt), .viol_cnt(viol_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic        udf;
    logic [31:0] ra;
  } ent_t;

  ent_t        mq[$];
  bit          m_req, m_lost;
  logic [1:0]  m_code;
  logic [31:0] m_pc, m_exp, m_act;
  int unsigned m_match, m_viol;

  function automatic logic [15:0] sat16(int unsigned v);
    return (v > 32'hFFFF) ? 16'hFFFF : v[15:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_req = 0; m_lost = 0; m_code = 0; m_pc = 0; m_exp = 0; m_act = 0;
    m_match = 0; m_viol = 0;
  endtask

  task automatic model_step();
    bit ap, ar, v;
    logic [1:0] c;
    logic [31:0] p, e, a;
    ent_t ent;
    ap = pop_valid && !ex_freeze && chk_en;
    ar = ret_valid && !ex_freeze && chk_en;
    v = 0; c = 0; p = 0; e = 0; a = 0;
    if (!chk_en) mq.delete();
    if (ap && !ar && mq.size() == DEPTH) begin
      v = 1; c = 2'b11; e = pop_ra;
    end else begin
      if (ap) mq.push_back('{pop_empty, pop_ra});
      if (ar) begin
        p = ret_pc; a = ret_target;
        if (mq.size() == 0) begin
          v = 1; c = 2'b11;
        end else begin
          ent = mq.pop_front();
          if (ent.udf) begin v = 1; c = 2'b10; end
          else if (ent.ra != ret_target) begin v = 1; c = 2'b01; e = ent.ra; end
          else m_match++;
        end
      end
    end
    if (v) m_viol++;
    if (m_req) begin
      if (v) m_lost = 1;
      if (viol_ack) m_req = 0;
    end else if (v) begin
      m_req = 1; m_code = c; m_pc = p; m_exp = e; m_act = a;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("req",   32'(viol_req),  32'(m_req));
    chk("code",  32'(viol_code), 32'(m_code));
    chk("pc",    viol_pc,        m_pc);
    chk("exp",   viol_exp,       m_exp);
    chk("act",   viol_act,       m_act);
    chk("lost",  32'(viol_lost), 32'(m_lost));
    chk("match", 32'(match_cnt), 32'(sat16(m_match)));
    chk("viol",  32'(viol_cnt),  32'(sat16(m_viol)));
    chk("busy",  32'(busy),      32'(mq.size() != 0 || m_req));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    pop_valid = 0; pop_empty = 0; ret_valid = 0; viol_ack = 0;
    pop_ra = 0; ret_target = 0; ret_pc = 0; ex_freeze = 0; chk_en = 1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        pv; logic [31:0] pra; logic pe;
    logic        rv; logic [31:0] rt;  logic [31:0] rpc; logic ack;
    logic        e_req; logic [1:0] e_code;
    logic [31:0] e_pc, e_exp, e_act;
    logic        e_lost; logic [15:0] e_m, e_v; logic e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic pv, logic [31:0] pra, logic pe, logic rv,
                              logic [31:0] rt, logic [31:0] rpc, logic ack,
                              logic er, logic [1:0] ec, logic [31:0] epc,
                              logic [31:0] eex, logic [31:0] eac, logic el,
                              logic [15:0] em, logic [15:0] ev, logic eb);
    vec_t r;
    r.pv = pv; r.pra = pra; r.pe = pe; r.rv = rv; r.rt = rt; r.rpc = rpc; r.ack = ack;
    r.e_req = er; r.e_code = ec; r.e_pc = epc; r.e_exp = eex; r.e_act = eac;
    r.e_lost = el; r.e_m = em; r.e_v = ev; r.e_busy = eb;
    return r;
  endfunction

  initial begin
    // pop -> ret match
    vt.push_back(mk(1,32'h2004,0, 0,0,0,0,          0,0,0,0,0,                 0,0,0,1));
    vt.push_back(mk(0,0,0,        0,0,0,0,          0,0,0,0,0,                 0,0,0,1));
    vt.push_back(mk(0,0,0,        1,32'h2004,32'h1000,0, 0,0,0,0,0,           0,1,0,0));
    // mismatch, held until ack
    vt.push_back(mk(1,32'h3008,0, 0,0,0,0,          0,0,0,0,0,                 0,1,0,1));
    vt.push_back(mk(0,0,0,        1,32'h3010,32'h4000,0, 1,1,32'h4000,32'h3008,32'h3010, 0,1,1,1));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0,0,0,      0,0,0,0,          1,1,32'h4000,32'h3008,32'h3010, 0,1,1,1));
    vt.push_back(mk(0,0,0,        0,0,0,1,          0,1,32'h4000,32'h3008,32'h3010, 0,1,1,0));
    // underflow, then lost mismatch during report
    vt.push_back(mk(1,32'h5000,1, 0,0,0,0,          0,1,32'h4000,32'h3008,32'h3010, 0,1,1,1));
    vt.push_back(mk(0,0,0,        1,32'h5000,32'h6000,0, 1,2,32'h6000,0,32'h5000, 0,1,2,1));
    vt.push_back(mk(1,32'h7000,0, 0,0,0,0,          1,2,32'h6000,0,32'h5000,   0,1,2,1));
    vt.push_back(mk(0,0,0,        1,32'h7004,32'h7100,0, 1,2,32'h6000,0,32'h5000, 1,1,3,1));
    vt.push_back(mk(0,0,0,        0,0,0,1,          0,2,32'h6000,0,32'h5000,   1,1,3,0));
    vt.push_back(mk(0,0,0,        0,0,0,0,          0,2,32'h6000,0,32'h5000,   1,1,3,0));
    // overflow on fifth pop
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(1,32'h8000+32'(4*i),0, 0,0,0,0, 0,2,32'h6000,0,32'h5000, 1,1,3,1));
    vt.push_back(mk(1,32'h8010,0, 0,0,0,0,          1,3,0,32'h8010,0,          1,1,4,1));
    vt.push_back(mk(0,0,0,        0,0,0,1,          0,3,0,32'h8010,0,          1,1,4,1));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(0,0,0, 1,32'h8000+32'(4*i),32'h8100,0, 0,3,0,32'h8010,0,
                      1,16'(2+i),4,(i != 3)));
    // bypass match, then orphan ret
    vt.push_back(mk(1,32'h100,0,  1,32'h100,32'h200,0, 0,3,0,32'h8010,0,      1,6,4,0));
    vt.push_back(mk(0,0,0,        1,32'h9999,32'h9000,0, 1,3,32'h9000,0,32'h9999, 1,6,5,1));
    vt.push_back(mk(0,0,0,        0,0,0,1,          0,3,32'h9000,0,32'h9999,   1,6,5,0));
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] m_before;
    idle_inputs();
    model_reset();
    #12;
    chk("rst_req",  32'(viol_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt",  32'(match_cnt) | 32'(viol_cnt), 0);
    chk("rst_code", 32'(viol_code), 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      pop_valid = vt[i].pv; pop_ra = vt[i].pra; pop_empty = vt[i].pe;
      ret_valid = vt[i].rv; ret_target = vt[i].rt; ret_pc = vt[i].rpc; viol_ack = vt[i].ack;
      cycle();
      chk($sformatf("v%0d_req", i),  32'(viol_req),  32'(vt[i].e_req));
      chk($sformatf("v%0d_code", i), 32'(viol_code), 32'(vt[i].e_code));
      chk($sformatf("v%0d_pc", i),   viol_pc,        vt[i].e_pc);
      chk($sformatf("v%0d_exp", i),  viol_exp,       vt[i].e_exp);
      chk($sformatf("v%0d_act", i),  viol_act,       vt[i].e_act);
      chk($sformatf("v%0d_lost", i), 32'(viol_lost), 32'(vt[i].e_lost));
      chk($sformatf("v%0d_m", i),    32'(match_cnt), 32'(vt[i].e_m));
      chk($sformatf("v%0d_v", i),    32'(viol_cnt),  32'(vt[i].e_v));
      chk($sformatf("v%0d_busy", i), 32'(busy),      32'(vt[i].e_busy));
    end
    idle_inputs();

    // freeze: mismatching pop+ret must be ignored
    m_before = match_cnt;
    ex_freeze = 1; pop_valid = 1; pop_ra = 32'hAAAA; ret_valid = 1; ret_target = 32'hBBBB;
    cycle();
    chk("frz_req",  32'(viol_req), 0);
    chk("frz_busy", 32'(busy), 0);
    chk("frz_cnt",  32'(viol_cnt), 5);
    idle_inputs();

    // chk_en low flushes queued entries
    pop_valid = 1; pop_ra = 32'h1234; cycle(); cycle();
    idle_inputs(); chk_en = 0; cycle();
    chk("flush_busy", 32'(busy), 0);
    idle_inputs();
    ret_valid = 1; ret_target = 32'h1234; ret_pc = 32'h55; cycle();
    chk("flush_orphan", 32'(viol_code), 3);
    idle_inputs();

    // asynchronous reset mid-report
    #2 rst = 1;
    #1;
    chk("arst_req",  32'(viol_req), 0);
    chk("arst_code", 32'(viol_code), 0);
    chk("arst_lost", 32'(viol_lost), 0);
    chk("arst_flds", viol_pc | viol_exp | viol_act, 0);
    chk("arst_cnt",  32'(viol_cnt), 0);
    model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ex_freeze = ($urandom_range(0, 9) == 0);
      chk_en    = ($urandom_range(0, 39) != 0);
      pop_valid = $urandom_range(0, 1);
      pop_empty = ($urandom_range(0, 9) == 0);
      pop_ra    = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      ret_valid = $urandom_range(0, 1);
      ret_pc    = $urandom;
      viol_ack  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) != 0)
        ret_target = (mq.size() != 0) ? mq[0].ra : pop_ra;
      else
        ret_target = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      cycle();
    end
    idle_inputs();

    // saturation of match counter
    #2 rst = 1; #1; model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    pop_valid = 1; pop_ra = 32'h100; ret_valid = 1; ret_target = 32'h100;
    for (int n = 0; n < 65536 + 3; n++) begin
      model_step();
      @(posedge clk); #1;
    end
    compare_model();
    chk("sat_match", 32'(match_cnt), 32'hFFFF);
    chk("sat_viol",  32'(viol_cnt), 0);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
